// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadratic evaluation pipeline.
package quad_pkg;

    localparam int unsigned NUM_STAGES  = 3;
    localparam int unsigned MODE_SQUARE = 0;
    localparam int unsigned MODE_QUAD   = 1;

    // Working width wide enough for A*x*x + B*x + C with WIDTH-bit operands.
    function automatic int unsigned calc_width(input int unsigned width);
        return 3 * width + 2;
    endfunction

endpackage

// File: rtl/quad_stage.sv
// One elastic register slice: payload plus valid bit. Loads when empty or when
// its current content drains downstream in the same cycle, otherwise holds.
module quad_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_c_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign ready_c_o = !valid_q || ready_i;

    // A bubble still loads so the valid bit clears; payload only moves on real data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_c_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/quad_eval_pipe.sv
// Three-stage elastic pipeline evaluating y = A*x*x + B*x + C (or x*x in square
// mode), with overflow flag for results beyond WIDTH bits.
module quad_eval_pipe
    import quad_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] A     = WIDTH'(101),
    parameter logic [WIDTH-1:0] B     = WIDTH'(59),
    parameter logic [WIDTH-1:0] C     = WIDTH'(76),
    parameter int unsigned      MODE  = MODE_QUAD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_valid_in,
    output logic             i_ready_out,
    output logic [WIDTH-1:0] o_y,
    output logic             o_ovf,
    output logic             o_valid_out,
    input  logic             o_ready_in
);

    localparam int unsigned CW     = calc_width(WIDTH);
    localparam int unsigned S1W    = 2 * CW;
    localparam int unsigned S3W    = WIDTH + 1;
    localparam bit          IS_QUAD = (MODE == MODE_QUAD);

    // Square mode zeroes the linear and constant terms and skips the A scaling.
    localparam logic [CW-1:0] A_EXT = CW'(A);
    localparam logic [CW-1:0] B_EXT = IS_QUAD ? CW'(B) : '0;
    localparam logic [CW-1:0] C_EXT = IS_QUAD ? CW'(C) : '0;

    logic [CW-1:0]  x_ext;
    logic [CW-1:0]  s1_sq_d;
    logic [CW-1:0]  s1_bx_d;
    logic [S1W-1:0] s1_data;
    logic           s1_valid;
    logic           s2_ready_c;
    logic [CW-1:0]  s1_sq;
    logic [CW-1:0]  s1_bx;

    logic [CW-1:0]  s2_d;
    logic [CW-1:0]  s2_data;
    logic           s2_valid;
    logic           s3_ready_c;

    logic [CW-1:0]  s3_sum;
    logic [S3W-1:0] s3_d;
    logic [S3W-1:0] s3_data;

    // Stage 1: x*x and B*x
    assign x_ext   = CW'(i_x);
    assign s1_sq_d = x_ext * x_ext;
    assign s1_bx_d = B_EXT * x_ext;

    quad_stage #(
        .W (S1W)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst),
        .valid_i   (i_valid_in),
        .data_i    ({s1_sq_d, s1_bx_d}),
        .ready_c_o (i_ready_out),
        .valid_o   (s1_valid),
        .data_o    (s1_data),
        .ready_i   (s2_ready_c)
    );

    assign s1_sq = s1_data[S1W-1:CW];
    assign s1_bx = s1_data[CW-1:0];

    // Stage 2: A*(x*x) + B*x
    assign s2_d = IS_QUAD ? (A_EXT * s1_sq + s1_bx) : s1_sq;

    quad_stage #(
        .W (CW)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst),
        .valid_i   (s1_valid),
        .data_i    (s2_d),
        .ready_c_o (s2_ready_c),
        .valid_o   (s2_valid),
        .data_o    (s2_data),
        .ready_i   (s3_ready_c)
    );

    // Stage 3: add C, fold upper bits into the overflow flag
    assign s3_sum = s2_data + C_EXT;
    assign s3_d   = {|s3_sum[CW-1:WIDTH], s3_sum[WIDTH-1:0]};

    quad_stage #(
        .W (S3W)
    ) u_stage3 (
        .clk       (clk),
        .rst_n     (rst),
        .valid_i   (s2_valid),
        .data_i    (s3_d),
        .ready_c_o (s3_ready_c),
        .valid_o   (o_valid_out),
        .data_o    (s3_data),
        .ready_i   (o_ready_in)
    );

    assign o_y   = s3_data[WIDTH-1:0];
    assign o_ovf = s3_data[WIDTH];

endmodule

// File: tb/tb_quad_eval_pipe.sv
// Bench for quad_eval_pipe: a full-quadratic and a square-mode instance share
// stimulus; a queue model checks every output, plus directed literal vectors.
module tb_quad_eval_pipe;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] x;
    logic         vin;
    logic         o_rdy;

    logic         q_ready, q_ovf, q_valid;
    logic [W-1:0] q_y;
    logic         s_ready, s_ovf, s_valid;
    logic [W-1:0] s_y;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q_x[$];
    int           n_acc = 0;
    int           n_out = 0;

    logic         hold;
    logic [W-1:0] hold_yq, hold_ys;
    logic         hold_oq, hold_os;

    quad_eval_pipe dut_q (
        .clk         (clk),
        .rst         (rst),
        .i_x         (x),
        .i_valid_in  (vin),
        .i_ready_out (q_ready),
        .o_y         (q_y),
        .o_ovf       (q_ovf),
        .o_valid_out (q_valid),
        .o_ready_in  (o_rdy)
    );

    quad_eval_pipe #(
        .MODE (0)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .i_x         (x),
        .i_valid_in  (vin),
        .i_ready_out (s_ready),
        .o_y         (s_y),
        .o_ovf       (s_ovf),
        .o_valid_out (s_valid),
        .o_ready_in  (o_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Full-precision result from the defining formula: {ovf, y}.
    function automatic logic [W:0] model(input logic [W-1:0] xv, input bit quad);
        longint unsigned xl;
        longint unsigned full;
        xl   = 64'(xv);
        full = quad ? (64'd101 * xl * xl + 64'd59 * xl + 64'd76) : (xl * xl);
        return {(full >> W) != 0, full[W-1:0]};
    endfunction

    // Compare process: reset state, ready rule, hold stability, ordered results.
    always @(negedge clk) begin : cmp
        logic [W:0] eq;
        logic [W:0] es;
        if (!rst) begin
            chk("rst_valid_q", 64'(q_valid), 0);
            chk("rst_valid_s", 64'(s_valid), 0);
            chk("rst_y_q", 64'(q_y), 0);
            chk("rst_ovf_q", 64'(q_ovf), 0);
            chk("rst_ready_q", 64'(q_ready), 1);
            q_x.delete();
            hold = 1'b0;
        end else begin
            chk("ready_q", 64'(q_ready), 64'((q_x.size() < 3) || o_rdy));
            chk("ready_s", 64'(s_ready), 64'((q_x.size() < 3) || o_rdy));
            if (hold) begin
                chk("hold_valid", 64'(q_valid), 1);
                chk("hold_y_q", 64'(q_y), 64'(hold_yq));
                chk("hold_ovf_q", 64'(q_ovf), 64'(hold_oq));
                chk("hold_y_s", 64'(s_y), 64'(hold_ys));
                chk("hold_ovf_s", 64'(s_ovf), 64'(hold_os));
            end
            if (q_valid || s_valid) begin
                if (q_x.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    eq = model(q_x[0], 1'b1);
                    es = model(q_x[0], 1'b0);
                    chk("valid_q", 64'(q_valid), 1);
                    chk("valid_s", 64'(s_valid), 1);
                    chk("y_q", 64'(q_y), 64'(eq[W-1:0]));
                    chk("ovf_q", 64'(q_ovf), 64'(eq[W]));
                    chk("y_s", 64'(s_y), 64'(es[W-1:0]));
                    chk("ovf_s", 64'(s_ovf), 64'(es[W]));
                    if (o_rdy) begin
                        void'(q_x.pop_front());
                        n_out++;
                    end
                end
            end
            hold    = q_valid && !o_rdy;
            hold_yq = q_y;
            hold_oq = q_ovf;
            hold_ys = s_y;
            hold_os = s_ovf;
            if (vin && q_ready) begin
                q_x.push_back(x);
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string n, input logic [W-1:0] yq, input logic oq,
                           input logic [W-1:0] ys, input logic os);
        chk({n, "_vq"}, 64'(q_valid), 1);
        chk({n, "_yq"}, 64'(q_y), 64'(yq));
        chk({n, "_oq"}, 64'(q_ovf), 64'(oq));
        chk({n, "_vs"}, 64'(s_valid), 1);
        chk({n, "_ys"}, 64'(s_y), 64'(ys));
        chk({n, "_os"}, 64'(s_ovf), 64'(os));
    endtask

    // Single input with downstream always ready: result exactly 3 cycles later.
    task automatic push_one(input string n, input logic [W-1:0] xv, input logic [W-1:0] yq,
                            input logic oq, input logic [W-1:0] ys, input logic os);
        x   = xv;
        vin = 1'b1;
        step();
        vin = 1'b0;
        step();
        chk({n, "_early"}, 64'(q_valid), 0);
        step();
        chk_out(n, yq, oq, ys, os);
        step();
        chk({n, "_gone"}, 64'(q_valid), 0);
    endtask

    initial begin : stim
        int cyc;
        int start_acc;
        int start_out;
        hold  = 1'b0;
        rst   = 1'b1;
        vin   = 1'b0;
        x     = '0;
        o_rdy = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("por_valid", 64'(q_valid), 0);
        chk("por_ready", 64'(q_ready), 1);
        chk("por_y", 64'(q_y), 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Back-to-back from the first edge after release
        x   = 16'd2;
        vin = 1'b1;
        step();
        x = 16'd0;
        step();
        vin = 1'b0;
        chk("b2b_early", 64'(q_valid), 0);
        step();
        chk_out("b2b0", 16'd598, 1'b0, 16'd4, 1'b0);
        step();
        chk_out("b2b1", 16'd76, 1'b0, 16'd0, 1'b0);
        step();
        chk("b2b_end", 64'(q_valid), 0);

        push_one("x3", 16'd3, 16'd1162, 1'b0, 16'd9, 1'b0);
        push_one("x300", 16'd300, 16'd63808, 1'b1, 16'd24464, 1'b1);
        push_one("xffff", 16'hFFFF, 16'd118, 1'b1, 16'd1, 1'b1);

        // Backpressure: six cycles with downstream stalled
        o_rdy = 1'b0;
        x     = 16'd1;
        vin   = 1'b1;
        step();
        x = 16'd2;
        step();
        x = 16'd3;
        step();
        x = 16'd4;
        chk("bp_ready_full", 64'(q_ready), 0);
        repeat (3) begin
            step();
            chk("bp_ready_held", 64'(q_ready), 0);
            chk_out("bp_hold", 16'd236, 1'b0, 16'd1, 1'b0);
        end
        o_rdy = 1'b1;
        #1;
        chk("bp_ready_release", 64'(q_ready), 1);
        chk_out("bp_r1", 16'd236, 1'b0, 16'd1, 1'b0);
        step();
        vin = 1'b0;
        chk_out("bp_r2", 16'd598, 1'b0, 16'd4, 1'b0);
        step();
        chk_out("bp_r3", 16'd1162, 1'b0, 16'd9, 1'b0);
        step();
        chk_out("bp_r4", 16'd1928, 1'b0, 16'd16, 1'b0);
        step();
        chk("bp_done", 64'(q_valid), 0);

        // Reset mid-flight discards both in-flight results
        x   = 16'd5;
        vin = 1'b1;
        step();
        x = 16'd6;
        step();
        vin = 1'b0;
        step();
        chk("mid_pre_valid", 64'(q_valid), 1);
        chk("mid_pre_y", 64'(q_y), 2896);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(q_valid), 0);
        chk("mid_rst_y", 64'(q_y), 0);
        chk("mid_rst_ovf", 64'(q_ovf), 0);
        chk("mid_rst_ready", 64'(q_ready), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) begin
            step();
            chk("mid_flush", 64'(q_valid), 0);
        end
        push_one("x7", 16'd7, 16'd5438, 1'b0, 16'd49, 1'b0);

        // Random valid/ready toggling against the model
        start_acc = n_acc;
        start_out = n_out;
        cyc       = 0;
        while ((n_acc - start_acc) < 10000 && cyc < 60000) begin
            vin   = ($urandom_range(0, 9) < 7);
            o_rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0:       x = '0;
                1:       x = '1;
                default: x = W'($urandom);
            endcase
            step();
            cyc++;
        end
        vin   = 1'b0;
        o_rdy = 1'b1;
        repeat (6) step();
        chk("rand_accepted", 64'(n_acc - start_acc), 10000);
        chk("rand_results", 64'(n_out - start_out), 10000);
        chk("rand_drained", 64'(q_x.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
